// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_SIGNED_EN to add the ctl0 port, signed operation and the FIXUP state.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef DIVIDER_SIGNED_EN
  input  logic             ctl0,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             DivZero,
  output logic             Zero,
  output logic             Overflow
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);
  localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef DIVIDER_SIGNED_EN
  localparam logic [1:0] S_FIXUP = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend in, quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] par_q, par_d;   // partial remainder; its WIDTH+1 form exists only as p_sh/t
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             dz_q, dz_d, zr_q, zr_d;
`ifdef DIVIDER_SIGNED_EN
  logic             negq_q, negq_d, negr_q, negr_d, ovf_q, ovf_d;
  logic             sa, sb;
`endif

  logic [WIDTH-1:0] a_in, b_in;
  logic [WIDTH:0]   p_sh, t;
  logic             qbit;

  always_comb begin
    a_in = A;
    b_in = B;
`ifdef DIVIDER_SIGNED_EN
    sa = ctl0 & A[WIDTH-1];
    sb = ctl0 & B[WIDTH-1];
    if (sa) a_in = -A;
    if (sb) b_in = -B;
`endif
  end

  // Subtract-and-test-sign step: T = P + ~{0,divisor} + 1
  always_comb begin
    p_sh = {1'b0, par_q, dvd_q[WIDTH-1]} >> 0;
    p_sh = {par_q, dvd_q[WIDTH-1]};
    t    = p_sh + ~{1'b0, dvs_q} + ONE;
    qbit = ~t[WIDTH];
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    zr_d    = zr_q;
`ifdef DIVIDER_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        dvd_d   = a_in;
        dvs_d   = b_in;
        par_d   = '0;
        cnt_d   = '0;
        dz_d    = (B == '0);
        state_d = S_RUN;
`ifdef DIVIDER_SIGNED_EN
        negq_d  = sa ^ sb;
        negr_d  = sa;
        ovf_d   = sa && (A[WIDTH-2:0] == '0) && (B == '1);
`endif
      end
      S_RUN: if (cnt_q == LAST) begin
`ifdef DIVIDER_SIGNED_EN
        state_d = S_FIXUP;
`else
        state_d = S_DONE;
        quo_d   = dvd_q;
        rem_d   = par_q;
        zr_d    = (dvd_q == '0);
`endif
      end else begin
        par_d = qbit ? t[WIDTH-1:0] : p_sh[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + CW'(1);
      end
`ifdef DIVIDER_SIGNED_EN
      S_FIXUP: begin
        quo_d   = negq_q ? -dvd_q : dvd_q;
        rem_d   = negr_q ? -par_q : par_q;
        zr_d    = (dvd_q == '0);  // negation never changes zero-ness
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      zr_q    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      zr_q    <= zr_d;
`ifdef DIVIDER_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = (state_q == S_DONE);
  assign DivZero   = dz_q;
  assign Zero      = zr_q;
`ifdef DIVIDER_SIGNED_EN
  assign busy      = (state_q == S_RUN) || (state_q == S_FIXUP);
  assign Overflow  = ovf_q;
`else
  assign busy      = (state_q == S_RUN);
  assign Overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: a cycle-level acceptance model pushes expected results,
// a negedge monitor checks busy every cycle and pops/compares on each done pulse.
`timescale 1ns/1ps
module tb_seq_divider;
  localparam int W = 32;
`ifdef DIVIDER_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         ctl0 = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, DivZero, Zero, Overflow;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
`ifdef DIVIDER_SIGNED_EN
    .ctl0(ctl0),
`endif
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .DivZero(DivZero), .Zero(Zero), .Overflow(Overflow)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         zr;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   bcnt = 0;   // cycles until the model's divider is idle again

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Truncating division on magnitudes; divide-by-zero yields all ones / dividend.
  function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic na, nb;
    logic [W-1:0] ma, mb, q, r;
    na = s & a[W-1];
    nb = s & b[W-1];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    if (mb == 0) begin q = '1; r = ma; end
    else begin q = ma / mb; r = ma % mb; end
    if (na ^ nb) q = -q;
    if (na) r = -r;
    e.q = q; e.r = r;
    e.dz = (b == 0);
    e.zr = (q == 0);
    e.ov = s && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
    e.acc = 0;
    return e;
  endfunction

  // Reference acceptance model: start only counts when the divider is idle.
  initial begin
    exp_t e;
    logic smode;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        bcnt = 0;
        sb_q.delete();
      end else begin
        cyc++;
`ifdef DIVIDER_SIGNED_EN
        smode = ctl0;
`else
        smode = 1'b0;
`endif
        if (bcnt > 0) bcnt--;
        else if (start) begin
          e = ref_div(A, B, smode);
          e.acc = cyc;
          sb_q.push_back(e);
          bcnt = LAT + 1;
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    logic exp_done;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_done = (bcnt == 1);
        chk("busy", busy, bcnt >= 2);
        chk("done", done, exp_done);
        if (exp_done && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          if (done) begin
            chk("latency",   cyc - e.acc, LAT);
            chk("quotient",  quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("DivZero",   DivZero, e.dz);
            chk("Zero",      Zero, e.zr);
            chk("Overflow",  Overflow, e.ov);
          end
        end
      end
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; ctl0 = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".quotient"},  quotient, 0);
    chk({tag, ".remainder"}, remainder, 0);
    chk({tag, ".busy"},      busy, 0);
    chk({tag, ".done"},      done, 0);
    chk({tag, ".DivZero"},   DivZero, 0);
    chk({tag, ".Zero"},      Zero, 0);
    chk({tag, ".Overflow"},  Overflow, 0);
  endtask

  initial begin
    logic s;
    logic [W-1:0] ra, rb;
    repeat (2) @(posedge clk);
    #1 chk_zero_outputs("reset");
    @(posedge clk); #2 reset = 1'b0;

    op(32'd100, 32'd7, 1'b0);
    op(32'hFFFF_FFFF, 32'd1, 1'b0);
    op(32'd5, 32'd9, 1'b0);
    op(32'd1234, 32'd0, 1'b0);
    op(32'd0, 32'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = ra >> $urandom_range(0, 31);
        default: rb = (i % 8 == 3) ? 32'd0 : ra + 32'd1;
      endcase
`ifdef DIVIDER_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      op(ra, rb, s);
    end

    // start held high with operands changing every cycle
    @(negedge clk);
    ctl0 = 1'b0; start = 1'b1;
    for (int i = 0; i < 2 * LAT + 8; i++) begin
      A = $urandom; B = $urandom_range(1, 1000);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    // re-pulse mid-RUN must be ignored
    @(negedge clk);
    A = 32'd999; B = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    A = 32'd77; B = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    // asynchronous reset at iteration 10
    @(negedge clk);
    A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_zero_outputs("midreset");
    @(posedge clk); #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    op(32'd1000, 32'd3, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    op(-32'sd7, 32'd2, 1'b1);
    op(32'd7, -32'sd2, 1'b1);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    op(-32'sd7, 32'd0, 1'b1);
    op(-32'sd7, 32'd2, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
